pkt_crc_sender: RTL and testbench



---
 rtl/pkt_crc_pkg.sv | 33 +++
 rtl/pkt_crc_sender_if.sv | 22 ++
 rtl/pkt_crc_sender_buf.sv | 29 ++
 rtl/pkt_crc_sender.sv | 151 +++++++++++++++
 tb/tb_pkt_crc_sender.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_crc_pkg.sv
// Shared types, CRC-32 constants and the word-wide CRC-32 step for pkt_crc_sender.
// The word-wide CRC step is a combinational helper used by the sender.
package pkt_crc_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      SEND    = 2'd1,
      CRC     = 2'd2,
      HDR     = 2'd3
   } pkt_state_t;

   localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

   // Non-reflected, MSB-first: data bit 31 enters the register first.
   function automatic logic [31:0] crc32_word(input logic [31:0] crc,
                                              input logic [31:0] data,
                                              input logic [31:0] poly = CRC32_POLY);
      logic [31:0] c;
      logic        fb;
      c = crc;
      for (int i = 31; i >= 0; i--) begin
         fb = c[31] ^ data[i];
         c  = {c[30:0], 1'b0};
         if (fb) begin
            c = c ^ poly;
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/pkt_crc_sender_if.sv
// Handshake bundle of pkt_crc_sender: upstream payload input, link output and busy flag.
// slave is the block's view, master is the surrounding environment's view.
interface pkt_crc_sender_if;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        busy;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_last, busy
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_last, busy
   );
endinterface

// File: rtl/pkt_crc_sender_buf.sv
// pkt_buf: DEPTH x 32 register file holding one packet, one write port and
// one asynchronous read port. Contents are not reset.
module pkt_buf #(
   parameter int DEPTH = 4,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clock,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
         always_ff @(posedge clock) begin
            if (we && (waddr == AW'(gi))) begin
               mem[gi] <= wdata;
            end
         end
      end
   endgenerate

   assign rdata = mem[raddr];

endmodule

// File: rtl/pkt_crc_sender.sv
// pkt_crc_sender: collects PKT_WORDS payload words, then sends them followed by a CRC-32 word.
// Optional header beat before the payload when PKT_CRC_SENDER_HDR_EN is defined.
module pkt_crc_sender
   import pkt_crc_pkg::*;
#(
   parameter int          PKT_WORDS  = 4,
   parameter logic [31:0] CRC_POLY   = CRC32_POLY,
   parameter logic [31:0] CRC_INIT   = CRC32_INIT,
   parameter logic [31:0] CRC_XOROUT = CRC32_XOROUT
) (
   input  logic           clock,
   input  logic           resetN,
   pkt_crc_sender_if.slave link
);

   localparam int            AW       = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
   localparam logic [AW-1:0] LAST_IDX = AW'(PKT_WORDS - 1);

   pkt_state_t    state_reg;
   logic [AW-1:0] wr_idx_reg;
   logic [AW-1:0] rd_idx_reg;
   logic [31:0]   crc_reg;
   logic [31:0]   out_data_reg;
   logic          out_valid_reg;
   logic          out_last_reg;
`ifdef PKT_CRC_SENDER_HDR_EN
   logic [15:0]   seq_reg;
`endif

   logic          accept;
   logic          last_accept;
   logic          out_fire;
   logic          last_beat;
   logic [AW-1:0] raddr;
   logic [31:0]   rdata;

   assign accept      = link.in_valid && (state_reg == COLLECT);
   assign last_accept = accept && (wr_idx_reg == LAST_IDX);
   assign out_fire    = out_valid_reg && link.out_ready;
   assign last_beat   = (rd_idx_reg == LAST_IDX);

   // Look one word ahead in SEND so out_data can be registered on each handshake;
   // every other state prefetches word 0.
   always_comb begin
      raddr = '0;
      if ((state_reg == SEND) && !last_beat) begin
         raddr = rd_idx_reg + 1'b1;
      end
   end

   pkt_buf #(
      .DEPTH (PKT_WORDS),
      .AW    (AW)
   ) u_buf (
      .clock (clock),
      .we    (accept),
      .waddr (wr_idx_reg),
      .wdata (link.in_data),
      .raddr (raddr),
      .rdata (rdata)
   );

`ifndef PKT_CRC_SENDER_HDR_EN
   // Word 0 is still being written when the packet is a single word.
   logic [31:0] first_word;
   assign first_word = (wr_idx_reg == '0) ? link.in_data : rdata;
`endif

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_reg     <= COLLECT;
         wr_idx_reg    <= '0;
         rd_idx_reg    <= '0;
         crc_reg       <= CRC_INIT;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
`ifdef PKT_CRC_SENDER_HDR_EN
         seq_reg       <= '0;
`endif
      end else begin
         case (state_reg)
            COLLECT: begin
               if (accept) begin
                  crc_reg <= crc32_word(crc_reg, link.in_data, CRC_POLY);
                  if (last_accept) begin
                     wr_idx_reg    <= '0;
                     rd_idx_reg    <= '0;
                     out_valid_reg <= 1'b1;
                     out_last_reg  <= 1'b0;
`ifdef PKT_CRC_SENDER_HDR_EN
                     state_reg     <= HDR;
                     out_data_reg  <= {seq_reg, 8'h00, 8'(PKT_WORDS)};
`else
                     state_reg     <= SEND;
                     out_data_reg  <= first_word;
`endif
                  end else begin
                     wr_idx_reg <= wr_idx_reg + 1'b1;
                  end
               end
            end
`ifdef PKT_CRC_SENDER_HDR_EN
            HDR: begin
               if (out_fire) begin
                  state_reg    <= SEND;
                  out_data_reg <= rdata;
               end
            end
`endif
            SEND: begin
               if (out_fire) begin
                  if (last_beat) begin
                     state_reg    <= CRC;
                     rd_idx_reg   <= '0;
                     out_data_reg <= crc_reg ^ CRC_XOROUT;
                     out_last_reg <= 1'b1;
                  end else begin
                     rd_idx_reg   <= rd_idx_reg + 1'b1;
                     out_data_reg <= rdata;
                  end
               end
            end
            CRC: begin
               if (out_fire) begin
                  state_reg     <= COLLECT;
                  crc_reg       <= CRC_INIT;
                  out_data_reg  <= '0;
                  out_valid_reg <= 1'b0;
                  out_last_reg  <= 1'b0;
`ifdef PKT_CRC_SENDER_HDR_EN
                  seq_reg       <= seq_reg + 1'b1;
`endif
               end
            end
            default: begin
               state_reg     <= COLLECT;
               out_valid_reg <= 1'b0;
               out_last_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign link.in_ready  = resetN && (state_reg == COLLECT);
   assign link.out_data  = out_data_reg;
   assign link.out_valid = out_valid_reg;
   assign link.out_last  = out_last_reg;
   assign link.busy      = (state_reg != COLLECT) || (wr_idx_reg != '0);

endmodule

// File: tb/tb_pkt_crc_sender.sv
// Bench for pkt_crc_sender: three instances (default, zero-init, single-word) driven with
// random payloads/backpressure and checked against a polynomial-division CRC model.
module tb_pkt_crc_sender;
   import pkt_crc_pkg::*;

`ifdef PKT_CRC_SENDER_HDR_EN
   localparam int HDR_BEATS = 1;
`else
   localparam int HDR_BEATS = 0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pkt_crc_sender_if ifa ();
   pkt_crc_sender_if ifb ();
   pkt_crc_sender_if ifc ();

   pkt_crc_sender #(.PKT_WORDS(4)) dut_a (.clock(clk), .resetN(rst_n), .link(ifa.slave));
   pkt_crc_sender #(.PKT_WORDS(4), .CRC_INIT(32'h0), .CRC_XOROUT(32'h0))
      dut_b (.clock(clk), .resetN(rst_n), .link(ifb.slave));
   pkt_crc_sender #(.PKT_WORDS(1)) dut_c (.clock(clk), .resetN(rst_n), .link(ifc.slave));

   logic [31:0] i_data  [3];
   logic        i_valid [3];
   logic        o_ready [3];
   logic [31:0] o_data  [3];
   logic        o_valid [3];
   logic        o_last  [3];
   logic        rdy     [3];
   logic        bsy     [3];

   assign ifa.in_data = i_data[0];  assign ifa.in_valid = i_valid[0];  assign ifa.out_ready = o_ready[0];
   assign ifb.in_data = i_data[1];  assign ifb.in_valid = i_valid[1];  assign ifb.out_ready = o_ready[1];
   assign ifc.in_data = i_data[2];  assign ifc.in_valid = i_valid[2];  assign ifc.out_ready = o_ready[2];
   assign o_data[0] = ifa.out_data; assign o_valid[0] = ifa.out_valid; assign o_last[0] = ifa.out_last;
   assign o_data[1] = ifb.out_data; assign o_valid[1] = ifb.out_valid; assign o_last[1] = ifb.out_last;
   assign o_data[2] = ifc.out_data; assign o_valid[2] = ifc.out_valid; assign o_last[2] = ifc.out_last;
   assign rdy[0] = ifa.in_ready;    assign rdy[1] = ifb.in_ready;      assign rdy[2] = ifc.in_ready;
   assign bsy[0] = ifa.busy;        assign bsy[1] = ifb.busy;          assign bsy[2] = ifc.busy;

   int          n_checks = 0;
   int          n_errors = 0;
   int          pw      [3];
   logic [31:0] init_v  [3];
   logic [31:0] xor_v   [3];
   logic [15:0] seq_m   [3];
   int          beats_cnt;
   int          lasts_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // CRC as the remainder of (M(x)*x^32 + INIT(x)*x^n) mod P(x), by long division.
   function automatic logic [31:0] crc_ref(input logic [31:0] init, input logic [31:0] w[$]);
      int          n;
      bit          b[];
      logic [32:0] g;
      logic [31:0] word;
      logic [31:0] r;
      n = w.size() * 32;
      b = new[n + 32];
      g = {1'b1, CRC32_POLY};
      for (int k = 0; k < n; k++) begin
         word = w[k / 32];
         b[k] = word[31 - (k % 32)];
      end
      for (int k = 0; k < 32; k++) b[k] = b[k] ^ init[31 - k];
      for (int k = 0; k < n; k++) begin
         if (b[k]) begin
            for (int j = 0; j < 33; j++) b[k + j] = b[k + j] ^ g[32 - j];
         end
      end
      r = '0;
      for (int k = 0; k < 32; k++) r[31 - k] = b[n + k];
      return r;
   endfunction

   task automatic send_words(input int d, input logic [31:0] w[$]);
      int t;
      foreach (w[i]) begin
         i_valid[d] = 1'b1;
         i_data[d]  = w[i];
         t = 0;
         while (rdy[d] !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
         end
         chk($sformatf("accept_wait[%0d]", d), 32'(rdy[d]), 32'd1);
         @(negedge clk);
      end
      i_valid[d] = 1'b0;
   endtask

   task automatic recv_pkt(input int d, input logic [31:0] w[$], input int pct);
      logic [31:0] exp_q[$];
      bit          r;
      int          stalls;
      int          last_i;
      exp_q = {};
      if (HDR_BEATS == 1) exp_q.push_back({seq_m[d], 8'h00, 8'(pw[d])});
      foreach (w[i]) exp_q.push_back(w[i]);
      exp_q.push_back(crc_ref(init_v[d], w) ^ xor_v[d]);
      last_i = exp_q.size() - 1;
      for (int i = 0; i <= last_i; i++) begin
         r = 1'b0;
         stalls = 0;
         while (!r) begin
            chk($sformatf("out_valid[%0d] beat%0d", d, i), 32'(o_valid[d]), 32'd1);
            chk($sformatf("out_data[%0d] beat%0d", d, i), o_data[d], exp_q[i]);
            chk($sformatf("out_last[%0d] beat%0d", d, i), 32'(o_last[d]), 32'(i == last_i));
            chk($sformatf("in_ready_low[%0d] beat%0d", d, i), 32'(rdy[d]), 32'd0);
            r = ($urandom_range(99) < pct) || (stalls > 20);
            stalls++;
            o_ready[d] = r;
            @(negedge clk);
         end
         beats_cnt++;
         if (i == last_i) lasts_cnt++;
         $display("pkt[%0d] beat %0d data=%h last=%0d stalls=%0d", d, i, exp_q[i], i == last_i, stalls - 1);
      end
      o_ready[d] = 1'b0;
      seq_m[d]++;
      chk($sformatf("idle_valid[%0d]", d), 32'(o_valid[d]), 32'd0);
      chk($sformatf("idle_busy[%0d]", d), 32'(bsy[d]), 32'd0);
      chk($sformatf("idle_ready[%0d]", d), 32'(rdy[d]), 32'd1);
   endtask

   initial begin
      logic [31:0] w[$];
      logic [31:0] d6[6];
      int          acc;
      bit          was;

      pw = '{4, 4, 1};
      init_v = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF};
      xor_v  = '{32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF};
      for (int d = 0; d < 3; d++) begin
         seq_m[d] = '0; i_valid[d] = 1'b0; o_ready[d] = 1'b0; i_data[d] = '0;
      end
      beats_cnt = 0;
      lasts_cnt = 0;

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk("rst_out_valid", 32'(o_valid[d]), 32'd0);
         chk("rst_out_last", 32'(o_last[d]), 32'd0);
         chk("rst_out_data", o_data[d], 32'd0);
         chk("rst_busy", 32'(bsy[d]), 32'd0);
         chk("rst_in_ready", 32'(rdy[d]), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(rdy[0]), 32'd1);

      // Basic zero packet, zero init/xorout
      w = '{32'd0, 32'd0, 32'd0, 32'd0};
      send_words(1, w);
      recv_pkt(1, w, 100);

      // Single-word packets with random backpressure
      for (int p = 0; p < 2; p++) begin
         w = '{$urandom()};
         send_words(2, w);
         recv_pkt(2, w, 50);
      end

      // Known data on the default instance
      w = '{32'd10, 32'd40, 32'd10, 32'd40};
      send_words(0, w);
      recv_pkt(0, w, 100);

      // Three back-to-back random packets with 50% out_ready
      beats_cnt = 0;
      lasts_cnt = 0;
      for (int p = 0; p < 3; p++) begin
         w = {};
         for (int k = 0; k < 4; k++) w.push_back($urandom());
         send_words(0, w);
         recv_pkt(0, w, 50);
      end
      chk("backpressure_beats", beats_cnt, 3 * (4 + 1 + HDR_BEATS));
      chk("backpressure_lasts", lasts_cnt, 3);

      // Upstream overrun: in_valid held for 6 cycles from idle
      for (int k = 0; k < 6; k++) d6[k] = $urandom();
      acc = 0;
      i_valid[0] = 1'b1;
      for (int c = 0; c < 6; c++) begin
         i_data[0] = d6[acc];
         was = rdy[0];
         @(negedge clk);
         if (was) acc++;
      end
      i_valid[0] = 1'b0;
      chk("overrun_accepts", acc, 4);
      w = '{d6[0], d6[1], d6[2], d6[3]};
      recv_pkt(0, w, 70);
      w = '{d6[4], d6[5], $urandom(), $urandom()};
      send_words(0, w);
      recv_pkt(0, w, 100);

      // Reset pulsed mid-SEND
      w = '{$urandom(), $urandom(), $urandom(), $urandom()};
      send_words(0, w);
      o_ready[0] = 1'b1;
      repeat (2) @(negedge clk);
      o_ready[0] = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(o_valid[0]), 32'd0);
      chk("midrst_out_last", 32'(o_last[0]), 32'd0);
      chk("midrst_busy", 32'(bsy[0]), 32'd0);
      chk("midrst_in_ready", 32'(rdy[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int d = 0; d < 3; d++) seq_m[d] = '0;
      @(negedge clk);
      chk("after_rst_valid", 32'(o_valid[0]), 32'd0);
      w = '{$urandom(), $urandom(), $urandom(), $urandom()};
      send_words(0, w);
      recv_pkt(0, w, 100);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
